prince_arbiter: RTL

Two-requester arbiter and sequencer that shares one masked PRINCE encryption/decryption core (two 64-bit shares, 128-bit key, `enc` select, `done` flag) between two independent clients. It accepts a job over a valid/ready handshake and chooses round-robin between clients. It drives the core's start/enable and holds the operands stable, waits for the core's `done`, then returns the ciphertext shares to the requester that issued the job. Share separation is preserved end to end: shares are never combined, and idle datapaths carry zero.

---
 rtl/prince_arb_pkg.sv | 23 ++
 rtl/prince_arb_rr.sv | 35 +++
 rtl/prince_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/prince_arb_pkg.sv
// Shared types and constants for the two-requester PRINCE core arbiter.
package prince_arb_pkg;

    localparam int SHARE_W = 64;
    localparam int KEY_W   = 128;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    // Select by masking against zero so an unselected share never reaches the datapath.
    function automatic logic [SHARE_W-1:0] share_gate(input logic [SHARE_W-1:0] i_d,
                                                      input logic i_sel);
        return i_d & {SHARE_W{i_sel}};
    endfunction

endpackage

// File: rtl/prince_arb_rr.sv
// Two-way round-robin grant; on a tie the requester not recorded in r_last wins.
module prince_arb_rr
    import prince_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_a_valid,
    input  logic i_b_valid,
    input  logic i_accept,
    output logic o_grant,
    output logic o_grant_valid
);

    logic r_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= REQ_B;
        end else if (i_accept) begin
            r_last <= o_grant;
        end
    end

    always_comb begin
        o_grant_valid = i_a_valid | i_b_valid;
        if (i_a_valid && i_b_valid) begin
            o_grant = ~r_last;
        end else if (i_b_valid) begin
            o_grant = REQ_B;
        end else begin
            o_grant = REQ_A;
        end
    end

endmodule

// File: rtl/prince_arbiter.sv
// Shares one masked PRINCE core between two clients; IDLE->LAUNCH->BUSY->RESP per job.
// Optional BUSY watchdog with sticky err output: define PRINCE_ARB_WDOG_EN.
module prince_arbiter
    import prince_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req_valid,
    output logic               a_req_ready,
    input  logic               a_enc,
    input  logic [SHARE_W-1:0] a_p0,
    input  logic [SHARE_W-1:0] a_p1,
    input  logic [KEY_W-1:0]   a_k,
    output logic               a_rsp_valid,
    input  logic               a_rsp_ready,
    output logic [SHARE_W-1:0] a_c0,
    output logic [SHARE_W-1:0] a_c1,
    input  logic               b_req_valid,
    output logic               b_req_ready,
    input  logic               b_enc,
    input  logic [SHARE_W-1:0] b_p0,
    input  logic [SHARE_W-1:0] b_p1,
    input  logic [KEY_W-1:0]   b_k,
    output logic               b_rsp_valid,
    input  logic               b_rsp_ready,
    output logic [SHARE_W-1:0] b_c0,
    output logic [SHARE_W-1:0] b_c1,
    output logic               core_rst,
    output logic               core_en,
    output logic               core_enc,
    output logic [SHARE_W-1:0] core_p0,
    output logic [SHARE_W-1:0] core_p1,
    output logic [KEY_W-1:0]   core_k,
    input  logic [SHARE_W-1:0] core_c0,
    input  logic [SHARE_W-1:0] core_c1,
    input  logic               core_done
`ifdef PRINCE_ARB_WDOG_EN
    ,
    output logic               err
`endif
);

    arb_state_e         r_state, w_state_next;
    logic               r_owner, r_enc;
    logic [SHARE_W-1:0] r_p0, r_p1, r_c0, r_c1;
    logic [KEY_W-1:0]   r_k;

    logic               w_grant, w_grant_valid, w_accept, w_sel_a, w_sel_b;
    logic               w_done, w_fire, w_timeout, w_wd_rst, w_rsp_a, w_rsp_b;
    logic               w_op_enc;
    logic [SHARE_W-1:0] w_op_p0, w_op_p1;
    logic [KEY_W-1:0]   w_op_k;

    prince_arb_rr u_rr (
        .clk           (clk),
        .rst           (rst),
        .i_a_valid     (a_req_valid),
        .i_b_valid     (b_req_valid),
        .i_accept      (w_accept),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    // Gated by rst so no ready is shown while reset is held.
    assign w_accept = rst && (r_state == IDLE) && w_grant_valid;
    assign w_sel_a  = w_accept && (w_grant == REQ_A);
    assign w_sel_b  = w_accept && (w_grant == REQ_B);
    assign w_done   = (r_state == BUSY) && core_done;
    assign w_fire   = (r_state == RESP) && ((r_owner == REQ_B) ? b_rsp_ready : a_rsp_ready);
    assign w_rsp_a  = (r_state == RESP) && (r_owner == REQ_A);
    assign w_rsp_b  = (r_state == RESP) && (r_owner == REQ_B);

    assign w_op_enc = w_sel_b ? (b_enc & w_sel_b) : (a_enc & w_sel_a);
    assign w_op_p0  = w_sel_b ? share_gate(b_p0, w_sel_b) : share_gate(a_p0, w_sel_a);
    assign w_op_p1  = w_sel_b ? share_gate(b_p1, w_sel_b) : share_gate(a_p1, w_sel_a);
    assign w_op_k   = w_sel_b ? (b_k & {KEY_W{w_sel_b}}) : (a_k & {KEY_W{w_sel_a}});

`ifdef PRINCE_ARB_WDOG_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_wd_rst, r_err;

    assign w_timeout = (r_state == BUSY) && !core_done && (r_wd_cnt == CNT_W'(TIMEOUT - 1));
    assign w_wd_rst  = r_wd_rst;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wd_cnt <= '0;
            r_wd_rst <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_wd_rst <= w_timeout;
            if (r_state == LAUNCH) begin
                r_wd_cnt <= '0;
            end else if (r_state == BUSY) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    // Without the watchdog BUSY waits forever and TIMEOUT has no effect.
    assign w_timeout = 1'b0 & (TIMEOUT < 1);
    assign w_wd_rst  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = LAUNCH;
            LAUNCH:  w_state_next = BUSY;
            BUSY: begin
                if (core_done) begin
                    w_state_next = RESP;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            RESP:    if (w_fire) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        a_req_ready = w_sel_a;
        b_req_ready = w_sel_b;
        a_rsp_valid = w_rsp_a;
        b_rsp_valid = w_rsp_b;
        a_c0        = share_gate(r_c0, w_rsp_a);
        a_c1        = share_gate(r_c1, w_rsp_a);
        b_c0        = share_gate(r_c0, w_rsp_b);
        b_c1        = share_gate(r_c1, w_rsp_b);
        core_en     = (r_state == LAUNCH);
        core_rst    = !rst | w_wd_rst;
        core_enc    = r_enc;
        core_p0     = r_p0;
        core_p1     = r_p1;
        core_k      = r_k;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner <= REQ_A;
            r_enc   <= 1'b0;
            r_p0    <= '0;
            r_p1    <= '0;
            r_k     <= '0;
            r_c0    <= '0;
            r_c1    <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant;
                r_enc   <= w_op_enc;
                r_p0    <= w_op_p0;
                r_p1    <= w_op_p1;
                r_k     <= w_op_k;
            end else if (w_done || w_timeout) begin
                r_enc   <= 1'b0;
                r_p0    <= '0;
                r_p1    <= '0;
                r_k     <= '0;
            end
            if (w_done) begin
                r_c0 <= core_c0;
                r_c1 <= core_c1;
            end else if (w_fire) begin
                r_c0 <= '0;
                r_c1 <= '0;
            end
        end
    end

endmodule
